// File: rtl/count_ctrl_pkg.sv
// Shared types and default widths for the count_ctrl interval timer.
// The state enum is also visible on the top's state_o debug port.
package count_ctrl_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int EXP_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : count_ctrl_pkg

// File: rtl/count_ctrl_count_en.sv
// Free-running up-counter with synchronous clear and enable.
// Clear has priority over enable; wraps naturally at 2^CNT_W.
module count_en
    import count_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : count_en

// File: rtl/count_ctrl.sv
// Interval timer controller: arms on start, counts to a latched period,
// pulses expire_o per interval and keeps sticky irq/overrun flags.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             expire_o,
    output logic             irq_o,
    output logic             overrun_o,
    output logic             err_o,
    output logic [EXP_W-1:0] exp_cnt_o,
    output state_e           state_o
);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] period_q,   period_d;
    logic             periodic_q, periodic_d;
    logic             irq_q,      irq_d;
    logic             overrun_q,  overrun_d;
    logic             expire_q,   expire_d;
    logic             err_q,      err_d;
    logic             busy_q,     busy_d;
    logic [EXP_W-1:0] exp_cnt_q,  exp_cnt_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             hit;
    logic [CNT_W-1:0] cnt;

    count_en #(
        .CNT_W (CNT_W)
    ) u_count_en (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt)
    );

    // period_q is never zero while RUN, so period_q-1 cannot underflow.
    assign hit = (state_q == ST_RUN) && (cnt == (period_q - CNT_W'(1)));

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        irq_d      = irq_q;
        overrun_d  = overrun_q;
        exp_cnt_d  = exp_cnt_q;
        expire_d   = 1'b0;
        err_d      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ack_i) begin
                    irq_d = 1'b0;
                end
                if (start_i && !stop_i) begin
                    if (period_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ST_RUN;
                        period_d   = period_i;
                        periodic_d = periodic_i;
                        cnt_clr    = 1'b1;
                        exp_cnt_d  = '0;
                        overrun_d  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                    irq_d   = 1'b0;
                end else if (hit) begin
                    cnt_clr  = 1'b1;
                    expire_d = 1'b1;
                    irq_d    = 1'b1;
                    if (irq_q && !ack_i) begin
                        overrun_d = 1'b1;
                    end
                    if (exp_cnt_q != {EXP_W{1'b1}}) begin
                        exp_cnt_d = exp_cnt_q + EXP_W'(1);
                    end
                    if (!periodic_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_en = 1'b1;
                    if (ack_i) begin
                        irq_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                    irq_d   = 1'b0;
                end else if (ack_i) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
            irq_q      <= 1'b0;
            overrun_q  <= 1'b0;
            expire_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            exp_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            irq_q      <= irq_d;
            overrun_q  <= overrun_d;
            expire_q   <= expire_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            exp_cnt_q  <= exp_cnt_d;
        end
    end

    assign busy_o    = busy_q;
    assign cnt_o     = cnt;
    assign expire_o  = expire_q;
    assign irq_o     = irq_q;
    assign overrun_o = overrun_q;
    assign err_o     = err_q;
    assign exp_cnt_o = exp_cnt_q;
    assign state_o   = state_q;

endmodule : count_ctrl

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl (CNT_W=8 so the all-ones period is reachable).
// Each step advances one clock and checks outputs 1ns after the rising edge.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

    localparam int CW = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic          stop_i;
    logic          periodic_i;
    logic [CW-1:0] period_i;
    logic          ack_i;
    logic          busy_o;
    logic [CW-1:0] cnt_o;
    logic          expire_o;
    logic          irq_o;
    logic          overrun_o;
    logic          err_o;
    logic [EW-1:0] exp_cnt_o;
    state_e        state_o;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    count_ctrl #(
        .CNT_W (CW),
        .EXP_W (EW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .periodic_i (periodic_i),
        .period_i   (period_i),
        .ack_i      (ack_i),
        .busy_o     (busy_o),
        .cnt_o      (cnt_o),
        .expire_o   (expire_o),
        .irq_o      (irq_o),
        .overrun_o  (overrun_o),
        .err_o      (err_o),
        .exp_cnt_o  (exp_cnt_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        assert (obs === exp_v) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_cnt"},     32'(cnt_o),     32'd0);
        chk({tag, "_busy"},    32'(busy_o),    32'd0);
        chk({tag, "_expire"},  32'(expire_o),  32'd0);
        chk({tag, "_irq"},     32'(irq_o),     32'd0);
        chk({tag, "_overrun"}, 32'(overrun_o), 32'd0);
        chk({tag, "_err"},     32'(err_o),     32'd0);
        chk({tag, "_expcnt"},  32'(exp_cnt_o), 32'd0);
        chk({tag, "_state"},   32'(state_o),   32'(ST_IDLE));
    endtask

    task automatic arm(input logic [CW-1:0] p, input logic per);
        start_i    = 1'b1;
        period_i   = p;
        periodic_i = per;
        tick();
        start_i    = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start_i = 1'b0; stop_i = 1'b0; periodic_i = 1'b0;
        period_i = '0; ack_i = 1'b0;
        tick();
        tick();
        chk_idle_reset("reset");
        rstn = 1'b1;

        // Periodic P=5 armed on the very first edge out of reset.
        arm(8'd5, 1'b1);
        chk("p5_e0_busy", 32'(busy_o), 32'd1);
        chk("p5_e0_cnt",  32'(cnt_o),  32'd0);
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("p5_cnt%0d", k), 32'(cnt_o), 32'(k));
            chk($sformatf("p5_noexp%0d", k), 32'(expire_o), 32'd0);
        end
        tick();
        chk("p5_e5_expire", 32'(expire_o),  32'd1);
        chk("p5_e5_cnt",    32'(cnt_o),     32'd0);
        chk("p5_e5_irq",    32'(irq_o),     32'd1);
        chk("p5_e5_expcnt", 32'(exp_cnt_o), 32'd1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("p5_e6_irq",    32'(irq_o),    32'd0);
        chk("p5_e6_expire", 32'(expire_o), 32'd0);
        chk("p5_e6_cnt",    32'(cnt_o),    32'd1);
        for (int k = 7; k <= 10; k++) tick();
        chk("p5_e10_expire",  32'(expire_o),  32'd1);
        chk("p5_e10_expcnt",  32'(exp_cnt_o), 32'd2);
        chk("p5_e10_overrun", 32'(overrun_o), 32'd0);
        for (int k = 11; k <= 15; k++) tick();
        chk("p5_e15_expire",  32'(expire_o),  32'd1);
        chk("p5_e15_expcnt",  32'(exp_cnt_o), 32'd3);
        chk("p5_e15_overrun", 32'(overrun_o), 32'd1);

        // start_i with a zero period while running is ignored.
        start_i = 1'b1; period_i = 8'd0; periodic_i = 1'b0;
        tick();
        start_i = 1'b0;
        chk("run_start_err",  32'(err_o),  32'd0);
        chk("run_start_busy", 32'(busy_o), 32'd1);
        chk("run_start_cnt",  32'(cnt_o),  32'd1);
        for (int k = 17; k <= 19; k++) tick();
        chk("p5_e19_cnt", 32'(cnt_o), 32'd4);
        // stop_i on the terminal-count edge suppresses the expiry.
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("stop_expire",  32'(expire_o),  32'd0);
        chk("stop_cnt",     32'(cnt_o),     32'd0);
        chk("stop_busy",    32'(busy_o),    32'd0);
        chk("stop_irq",     32'(irq_o),     32'd0);
        chk("stop_state",   32'(state_o),   32'(ST_IDLE));
        chk("stop_overrun", 32'(overrun_o), 32'd1);

        // Rejected start.
        start_i = 1'b1; period_i = 8'd0;
        tick();
        start_i = 1'b0;
        chk("err_pulse", 32'(err_o),  32'd1);
        chk("err_busy",  32'(busy_o), 32'd0);
        tick();
        chk("err_clear", 32'(err_o),  32'd0);

        // One-shot P=3.
        arm(8'd3, 1'b0);
        chk("os_e0_overrun", 32'(overrun_o), 32'd0);
        chk("os_e0_expcnt",  32'(exp_cnt_o), 32'd0);
        tick();
        tick();
        chk("os_e2_cnt", 32'(cnt_o), 32'd2);
        tick();
        chk("os_e3_expire", 32'(expire_o), 32'd1);
        chk("os_e3_state",  32'(state_o),  32'(ST_DONE));
        chk("os_e3_busy",   32'(busy_o),   32'd1);
        chk("os_e3_irq",    32'(irq_o),    32'd1);
        tick();
        chk("os_e4_expire", 32'(expire_o), 32'd0);
        chk("os_e4_cnt",    32'(cnt_o),    32'd0);
        chk("os_e4_busy",   32'(busy_o),   32'd1);
        tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("os_ack_busy",  32'(busy_o),  32'd0);
        chk("os_ack_irq",   32'(irq_o),   32'd0);
        chk("os_ack_state", 32'(state_o), 32'(ST_IDLE));

        // Periodic P=1: expiry every cycle, overrun, set-wins over ack, saturation.
        arm(8'd1, 1'b1);
        tick();
        chk("p1_e1_expire",  32'(expire_o),  32'd1);
        chk("p1_e1_overrun", 32'(overrun_o), 32'd0);
        tick();
        chk("p1_e2_expire",  32'(expire_o),  32'd1);
        chk("p1_e2_overrun", 32'(overrun_o), 32'd1);
        chk("p1_e2_expcnt",  32'(exp_cnt_o), 32'd2);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("p1_ack_expire", 32'(expire_o), 32'd1);
        chk("p1_ack_irq",    32'(irq_o),    32'd1);
        for (int k = 4; k <= 260; k++) tick();
        chk("p1_sat_expcnt", 32'(exp_cnt_o), 32'd255);
        chk("p1_sat_expire", 32'(expire_o),  32'd1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("p1_stop_busy", 32'(busy_o), 32'd0);

        // Reset in the middle of a run.
        arm(8'd2, 1'b1);
        tick();
        tick();
        chk("mid_irq", 32'(irq_o), 32'd1);
        tick();
        chk("mid_cnt", 32'(cnt_o), 32'd1);
        rstn = 1'b0;
        tick();
        chk_idle_reset("midrst");
        rstn = 1'b1;

        // All-ones period on the 8-bit counter.
        arm(8'd255, 1'b1);
        for (int k = 1; k <= 253; k++) tick();
        chk("p255_cnt253", 32'(cnt_o), 32'd253);
        tick();
        chk("p255_cnt254",    32'(cnt_o),    32'd254);
        chk("p255_noexp254",  32'(expire_o), 32'd0);
        tick();
        chk("p255_expire", 32'(expire_o), 32'd1);
        chk("p255_wrap",   32'(cnt_o),    32'd0);
        tick();
        chk("p255_cnt1",   32'(cnt_o),    32'd1);
        chk("p255_noexp1", 32'(expire_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule : tb_count_ctrl
